// File: rtl/rob_param_if.sv
// Bundles the allocate, writeback, commit and flush signals of rob_param.
// The slave modport is the ROB side and the master modport is the producer/consumer side.
// Ports:
//   alloc_*   : allocation request, entry fields, and the returned entry id.
//   wb_*      : NUM_WB writeback ports, packed so that port k occupies slice k.
//   commit_*  : registered retire information, valid for one cycle.
//   flush*    : one-cycle mispredict pulse and its redirect target.
//   count/empty : ROB occupancy.
interface rob_param_if #(
    parameter int unsigned IDX_W  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NUM_WB = 2
);
    logic                     alloc_valid;
    logic                     alloc_ready;
    logic [31:0]              alloc_pc;
    logic [31:0]              alloc_pred_pc;
    logic                     alloc_is_br;
    logic                     alloc_is_store;
    logic [4:0]               alloc_rd;
    logic [IDX_W-1:0]         alloc_id;

    logic [NUM_WB-1:0]        wb_valid;
    logic [NUM_WB*IDX_W-1:0]  wb_id;
    logic [NUM_WB*DATA_W-1:0] wb_value;
    logic [NUM_WB*32-1:0]     wb_target;

    logic                     commit_valid;
    logic [IDX_W-1:0]         commit_id;
    logic [4:0]               commit_rd;
    logic [DATA_W-1:0]        commit_value;
    logic                     commit_is_store;

    logic                     flush;
    logic [31:0]              flush_pc;

    logic [IDX_W:0]           count;
    logic                     empty;

    modport master (
        output alloc_valid, alloc_pc, alloc_pred_pc, alloc_is_br, alloc_is_store, alloc_rd,
        input  alloc_ready, alloc_id,
        output wb_valid, wb_id, wb_value, wb_target,
        input  commit_valid, commit_id, commit_rd, commit_value, commit_is_store,
        input  flush, flush_pc, count, empty
    );

    modport slave (
        input  alloc_valid, alloc_pc, alloc_pred_pc, alloc_is_br, alloc_is_store, alloc_rd,
        output alloc_ready, alloc_id,
        input  wb_valid, wb_id, wb_value, wb_target,
        output commit_valid, commit_id, commit_rd, commit_value, commit_is_store,
        output flush, flush_pc, count, empty
    );
endinterface

// File: rtl/rob_param.sv
// Parameterised reorder buffer: circular queue of DEPTH entries, NUM_WB writeback
// ports, in-order single retire per cycle, branch mispredict flush on retire.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset (dominates rdy)
//   rdy  : global enable; low holds all state and drops the commit/flush pulses
//   bus  : rob_param_if.slave (allocate, writeback, commit, flush, occupancy)
// Configuration macro ROB_WB_BYPASS_EN: when defined, a head entry receiving a
// writeback retires on that same edge using the writeback value/target; when
// undefined the head retires no earlier than the edge after its ready bit is set.
module rob_param #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned IDX_W  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NUM_WB = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdy,
    rob_param_if.slave bus
);
    localparam int unsigned CNT_W = IDX_W + 1;

    // entry storage
    logic [31:0]       pred_q   [DEPTH];
    logic [31:0]       target_q [DEPTH];
    logic [DATA_W-1:0] value_q  [DEPTH];
    logic [4:0]        rd_q     [DEPTH];
    logic [DEPTH-1:0]  is_br_q;
    logic [DEPTH-1:0]  is_store_q;
    logic [DEPTH-1:0]  ready_q;

    logic [IDX_W-1:0]  head_q;
    logic [IDX_W-1:0]  tail_q;
    logic [CNT_W-1:0]  count_q;

    logic              commit_valid_q;
    logic [IDX_W-1:0]  commit_id_q;
    logic [4:0]        commit_rd_q;
    logic [DATA_W-1:0] commit_value_q;
    logic              commit_is_store_q;
    logic              flush_q;
    logic [31:0]       flush_pc_q;

    logic [IDX_W-1:0]  wb_idx [NUM_WB];
    logic [DATA_W-1:0] wb_val [NUM_WB];
    logic [31:0]       wb_tgt [NUM_WB];
    logic [NUM_WB-1:0] wb_hit;

    logic              head_wb;
    logic [DATA_W-1:0] head_value;
    logic [31:0]       head_target;
    logic              commit_fire;
    logic              mispredict;
    logic              alloc_fire;

    // unpack the writeback port slices
    always_comb begin
        for (int k = 0; k < NUM_WB; k++) begin
            wb_idx[k] = bus.wb_id[k*IDX_W +: IDX_W];
            wb_val[k] = bus.wb_value[k*DATA_W +: DATA_W];
            wb_tgt[k] = bus.wb_target[k*32 +: 32];
        end
    end

    // head result: stored value, optionally overridden by a same-cycle writeback
    always_comb begin
        head_wb     = 1'b0;
        head_value  = value_q[head_q];
        head_target = target_q[head_q];
`ifdef ROB_WB_BYPASS_EN
        for (int k = 0; k < NUM_WB; k++) begin
            if (bus.wb_valid[k] && (wb_idx[k] == head_q)) begin
                head_wb     = 1'b1;
                head_value  = wb_val[k];
                head_target = wb_tgt[k];
            end
        end
`endif
    end

    // retire, mispredict and allocate decisions for this edge
    always_comb begin
        commit_fire = rdy && (count_q != '0) && (ready_q[head_q] || head_wb);
        mispredict  = commit_fire && is_br_q[head_q] && (head_target != pred_q[head_q]);
        alloc_fire  = rdy && bus.alloc_valid && (count_q != CNT_W'(DEPTH)) && !mispredict;
    end

    // a writeback only lands on an entry inside [head, head+count)
    always_comb begin
        for (int k = 0; k < NUM_WB; k++) begin
            wb_hit[k] = rdy && !mispredict && bus.wb_valid[k]
                        && (CNT_W'(IDX_W'(wb_idx[k] - head_q)) < count_q);
        end
    end

    // pointers, occupancy, ready bits and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q            <= '0;
            tail_q            <= '0;
            count_q           <= '0;
            ready_q           <= '0;
            commit_valid_q    <= 1'b0;
            commit_id_q       <= '0;
            commit_rd_q       <= '0;
            commit_value_q    <= '0;
            commit_is_store_q <= 1'b0;
            flush_q           <= 1'b0;
            flush_pc_q        <= '0;
        end else if (!rdy) begin
            commit_valid_q <= 1'b0;
            flush_q        <= 1'b0;
        end else begin
            commit_valid_q <= commit_fire;
            flush_q        <= mispredict;
            if (commit_fire) begin
                commit_id_q       <= head_q;
                commit_rd_q       <= rd_q[head_q];
                commit_value_q    <= head_value;
                commit_is_store_q <= is_store_q[head_q];
            end
            if (mispredict) begin
                flush_pc_q <= head_target;
                head_q     <= '0;
                tail_q     <= '0;
                count_q    <= '0;
                ready_q    <= '0;
            end else begin
                // later ports overwrite earlier ones on an id collision
                for (int k = 0; k < NUM_WB; k++) begin
                    if (wb_hit[k]) begin
                        ready_q[wb_idx[k]] <= 1'b1;
                    end
                end
                if (alloc_fire) begin
                    ready_q[tail_q] <= 1'b0;
                    tail_q          <= tail_q + IDX_W'(1);
                end
                if (commit_fire) begin
                    head_q <= head_q + IDX_W'(1);
                end
                case ({alloc_fire, commit_fire})
                    2'b10:   count_q <= count_q + CNT_W'(1);
                    2'b01:   count_q <= count_q - CNT_W'(1);
                    default: ;
                endcase
            end
        end
    end

    // entry payload; contents of free slots are don't-care so no reset
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            pred_q[tail_q]     <= bus.alloc_pred_pc;
            rd_q[tail_q]       <= bus.alloc_rd;
            is_br_q[tail_q]    <= bus.alloc_is_br;
            is_store_q[tail_q] <= bus.alloc_is_store;
        end
        for (int k = 0; k < NUM_WB; k++) begin
            if (wb_hit[k]) begin
                value_q[wb_idx[k]]  <= wb_val[k];
                target_q[wb_idx[k]] <= wb_tgt[k];
            end
        end
    end

    assign bus.alloc_ready     = (count_q != CNT_W'(DEPTH));
    assign bus.alloc_id        = tail_q;
    assign bus.count           = count_q;
    assign bus.empty           = (count_q == '0);
    assign bus.commit_valid    = commit_valid_q;
    assign bus.commit_id       = commit_id_q;
    assign bus.commit_rd       = commit_rd_q;
    assign bus.commit_value    = commit_value_q;
    assign bus.commit_is_store = commit_is_store_q;
    assign bus.flush           = flush_q;
    assign bus.flush_pc        = flush_pc_q;
endmodule

// File: tb/tb_rob_param.sv
// Bench for rob_param: directed scenarios plus randomized traffic, checked by a
// queue-based reference ROB and a commit scoreboard.
module tb_rob_param;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NUM_WB = 2;

    logic clk = 1'b0;
    logic rst;
    logic rdy;

    rob_param_if #(.IDX_W(IDX_W), .DATA_W(DATA_W), .NUM_WB(NUM_WB)) bus ();

    rob_param #(.DEPTH(DEPTH), .IDX_W(IDX_W), .DATA_W(DATA_W), .NUM_WB(NUM_WB)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]  id;
        logic [4:0]  rd;
        bit          is_br;
        bit          is_store;
        logic [31:0] pred;
        bit          ready;
        logic [31:0] value;
        logic [31:0] target;
    } ent_t;

    typedef struct {
        int          cyc;
        logic [3:0]  id;
        logic [4:0]  rd;
        logic [31:0] value;
        bit          is_store;
        bit          flush;
        logic [31:0] fpc;
    } exp_t;

    ent_t rob[$];
    exp_t exp_q[$];
    int   mtail = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // reference ROB: an ordered list of in-flight instructions
    task automatic model_step();
        bit          commit;
        bit          mis;
        logic [31:0] bv;
        logic [31:0] bt;
        logic [3:0]  wid;
        int          sz;
        exp_t        e;
        ent_t        n;
        if (rst) begin
            rob.delete();
            mtail = 0;
            return;
        end
        if (!rdy) return;
        sz     = rob.size();
        commit = 1'b0;
        mis    = 1'b0;
        if (sz > 0) begin
            bv     = rob[0].value;
            bt     = rob[0].target;
            commit = rob[0].ready;
`ifdef ROB_WB_BYPASS_EN
            for (int k = 0; k < NUM_WB; k++) begin
                wid = bus.wb_id[k*IDX_W +: IDX_W];
                if (bus.wb_valid[k] && wid == rob[0].id) begin
                    commit = 1'b1;
                    bv     = bus.wb_value[k*DATA_W +: DATA_W];
                    bt     = bus.wb_target[k*32 +: 32];
                end
            end
`endif
            if (commit) begin
                mis = rob[0].is_br && (bt != rob[0].pred);
                e   = '{cyc + 1, rob[0].id, rob[0].rd, bv, rob[0].is_store, mis, bt};
                exp_q.push_back(e);
            end
        end
        if (mis) begin
            rob.delete();
            mtail = 0;
            return;
        end
        for (int k = 0; k < NUM_WB; k++) begin
            wid = bus.wb_id[k*IDX_W +: IDX_W];
            if (bus.wb_valid[k]) begin
                foreach (rob[i]) begin
                    if (rob[i].id == wid) begin
                        rob[i].ready  = 1'b1;
                        rob[i].value  = bus.wb_value[k*DATA_W +: DATA_W];
                        rob[i].target = bus.wb_target[k*32 +: 32];
                    end
                end
            end
        end
        if (bus.alloc_valid && sz < int'(DEPTH)) begin
            n = '{4'(mtail), bus.alloc_rd, bus.alloc_is_br, bus.alloc_is_store,
                  bus.alloc_pred_pc, 1'b0, 32'h0, 32'h0};
            rob.push_back(n);
            mtail = (mtail + 1) % int'(DEPTH);
        end
        if (commit) void'(rob.pop_front());
    endtask

    task automatic check_state();
        chk("count", 64'(bus.count), 64'(rob.size()));
        chk("empty", 64'(bus.empty), 64'(rob.size() == 0));
        chk("alloc_ready", 64'(bus.alloc_ready), 64'(rob.size() != int'(DEPTH)));
        chk("alloc_id", 64'(bus.alloc_id), 64'(mtail));
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        #1;
        check_state();
    endtask

    task automatic idle_inputs();
        bus.alloc_valid    = 1'b0;
        bus.alloc_pc       = '0;
        bus.alloc_pred_pc  = '0;
        bus.alloc_is_br    = 1'b0;
        bus.alloc_is_store = 1'b0;
        bus.alloc_rd       = '0;
        bus.wb_valid       = '0;
        bus.wb_id          = '0;
        bus.wb_value       = '0;
        bus.wb_target      = '0;
    endtask

    task automatic set_alloc(input bit br, input bit st, input logic [4:0] rd,
                             input logic [31:0] pc, input logic [31:0] pred);
        bus.alloc_valid    = 1'b1;
        bus.alloc_is_br    = br;
        bus.alloc_is_store = st;
        bus.alloc_rd       = rd;
        bus.alloc_pc       = pc;
        bus.alloc_pred_pc  = pred;
    endtask

    task automatic set_wb(input int k, input logic [3:0] id, input logic [31:0] v,
                          input logic [31:0] t);
        bus.wb_valid[k]                  = 1'b1;
        bus.wb_id[k*IDX_W +: IDX_W]      = id;
        bus.wb_value[k*DATA_W +: DATA_W] = v;
        bus.wb_target[k*32 +: 32]        = t;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        rdy = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic alloc_n(input int n);
        for (int i = 0; i < n; i++) begin
            set_alloc(1'b0, i[0], 5'(i + 1), 32'h1000 + 32'(i * 4), 32'h1004 + 32'(i * 4));
            tick();
        end
        idle_inputs();
    endtask

    // edges from the writeback edge until commit_valid is seen, bounded
    task automatic wait_commit(input int max_cyc, output int lat);
        lat = 1;
        while (bus.commit_valid !== 1'b1 && lat < max_cyc) begin
            tick();
            lat++;
        end
    endtask

    // scoreboard: pops the expected retire whenever its cycle comes up
    always @(negedge clk) begin : monitor
        exp_t e;
        bit   ev;
        ev = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
        chk("commit_valid", 64'(bus.commit_valid), 64'(ev));
        if (ev) begin
            e = exp_q.pop_front();
            if (bus.commit_valid === 1'b1) begin
                chk("commit_id", 64'(bus.commit_id), 64'(e.id));
                chk("commit_rd", 64'(bus.commit_rd), 64'(e.rd));
                chk("commit_value", 64'(bus.commit_value), 64'(e.value));
                chk("commit_is_store", 64'(bus.commit_is_store), 64'(e.is_store));
                chk("flush", 64'(bus.flush), 64'(e.flush));
                if (e.flush) chk("flush_pc", 64'(bus.flush_pc), 64'(e.fpc));
            end
        end else begin
            chk("flush_idle", 64'(bus.flush), 64'h0);
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int          lat;
        int          pick;
        logic [3:0]  wid;
        logic [31:0] tgt;
        bit          heavy;

        do_reset();
        chk("reset_count", 64'(bus.count), 64'h0);
        chk("reset_commit_valid", 64'(bus.commit_valid), 64'h0);
        chk("reset_flush_pc", 64'(bus.flush_pc), 64'h0);

        // fill to DEPTH, then one more request that must be refused
        alloc_n(16);
        chk("full_alloc_ready", 64'(bus.alloc_ready), 64'h0);
        chk("full_alloc_id", 64'(bus.alloc_id), 64'h0);
        alloc_n(1);
        chk("full_drop_count", 64'(bus.count), 64'd16);

        // single result retire latency
        do_reset();
        set_alloc(1'b0, 1'b0, 5'd5, 32'h40, 32'h44);
        tick();
        idle_inputs();
        set_wb(0, 4'd0, 32'h1234, 32'h44);
        tick();
        idle_inputs();
        wait_commit(8, lat);
`ifdef ROB_WB_BYPASS_EN
        chk("retire_latency", 64'(lat), 64'd1);
`else
        chk("retire_latency", 64'(lat), 64'd2);
`endif
        chk("retire_rd", 64'(bus.commit_rd), 64'd5);
        chk("retire_value", 64'(bus.commit_value), 64'h1234);
        tick();
        chk("retire_pulse_once", 64'(bus.commit_valid), 64'h0);

        // mispredicted branch flushes the younger entries
        do_reset();
        set_alloc(1'b1, 1'b0, 5'd1, 32'h100, 32'h104);
        tick();
        alloc_n(3);
        set_wb(0, 4'd1, 32'h11, 32'h0);
        set_wb(1, 4'd2, 32'h22, 32'h0);
        tick();
        idle_inputs();
        set_wb(0, 4'd3, 32'h33, 32'h0);
        tick();
        idle_inputs();
        set_wb(0, 4'd0, 32'h55, 32'h200);
        tick();
        idle_inputs();
        wait_commit(8, lat);
        chk("br_commit_id", 64'(bus.commit_id), 64'h0);
        chk("br_flush", 64'(bus.flush), 64'h1);
        chk("br_flush_pc", 64'(bus.flush_pc), 64'h200);
        chk("br_flush_count", 64'(bus.count), 64'h0);
        for (int i = 0; i < 5; i++) tick();

        // two ports writing the same id: higher port wins
        do_reset();
        alloc_n(3);
        set_wb(0, 4'd2, 32'hA, 32'h0);
        set_wb(1, 4'd2, 32'hB, 32'h0);
        tick();
        idle_inputs();
        set_wb(0, 4'd0, 32'h7, 32'h0);
        set_wb(1, 4'd1, 32'h8, 32'h0);
        tick();
        idle_inputs();
        for (int i = 0; i < 10; i++) begin
            if (bus.commit_valid === 1'b1 && bus.commit_id == 4'd2) break;
            tick();
        end
        chk("wb_priority_value", 64'(bus.commit_value), 64'hB);

        // full ROB with a retiring head refuses the allocation
        do_reset();
        alloc_n(16);
`ifdef ROB_WB_BYPASS_EN
        set_wb(0, 4'd0, 32'h99, 32'h0);
        set_alloc(1'b0, 1'b0, 5'd9, 32'h0, 32'h0);
        tick();
`else
        set_wb(0, 4'd0, 32'h99, 32'h0);
        tick();
        idle_inputs();
        set_alloc(1'b0, 1'b0, 5'd9, 32'h0, 32'h0);
        tick();
`endif
        idle_inputs();
        chk("full_commit_valid", 64'(bus.commit_valid), 64'h1);
        chk("full_commit_count", 64'(bus.count), 64'd15);
        chk("full_commit_alloc_id", 64'(bus.alloc_id), 64'h0);

        // rdy low freezes a ready head
        do_reset();
        alloc_n(2);
        set_wb(0, 4'd1, 32'h21, 32'h0);
        tick();
        idle_inputs();
        set_wb(0, 4'd0, 32'h20, 32'h0);
        tick();
        idle_inputs();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("stall_commit_valid", 64'(bus.commit_valid), 64'h0);
`ifdef ROB_WB_BYPASS_EN
        chk("stall_count", 64'(bus.count), 64'd1);
`else
        chk("stall_count", 64'(bus.count), 64'd2);
`endif
        rdy = 1'b1;
        tick();
        chk("stall_release_commit", 64'(bus.commit_valid), 64'h1);

        // randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            heavy = ((i / 300) % 2) == 1;
            idle_inputs();
            rst = ($urandom_range(0, 599) == 0);
            rdy = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 9) < (heavy ? 8 : 5)) begin
                set_alloc($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                          5'($urandom_range(0, 31)), $urandom, $urandom);
            end
            for (int k = 0; k < NUM_WB; k++) begin
                if ($urandom_range(0, 9) < (heavy ? 3 : 6)) begin
                    if (rob.size() > 0 && $urandom_range(0, 7) != 0) begin
                        pick = $urandom_range(0, rob.size() - 1);
                        wid  = rob[pick].id;
                        tgt  = ($urandom_range(0, 3) != 0) ? rob[pick].pred : $urandom;
                    end else begin
                        wid = 4'($urandom_range(0, DEPTH - 1));
                        tgt = $urandom;
                    end
                    set_wb(k, wid, $urandom, tgt);
                end
            end
            tick();
        end

        // drain whatever is left
        idle_inputs();
        rst = 1'b0;
        rdy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            idle_inputs();
            if (rob.size() == 0 && exp_q.size() == 0) break;
            if (rob.size() > 0) set_wb(0, rob[0].id, $urandom, rob[0].pred);
            tick();
        end
        idle_inputs();
        tick();
        chk("final_empty", 64'(bus.empty), 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rob_param.md
ROB_PARAM -- requirements
Module: rob_param

Interface
REQ-001 Parameter DEPTH, default 16, entry count; SHALL be a power of two, 4..64.
REQ-002 Parameter IDX_W, default 4, log2(DEPTH), entry-id width.
REQ-003 Parameter DATA_W, default 32, result width.
REQ-004 Parameter NUM_WB, default 2, writeback port count, 1..4.
REQ-005 clk  in  1  clock; reset rst, synchronous, active-high; clock clk.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 rdy  in  1  global enable; low freezes all state.
REQ-008 alloc_valid  in  1  allocate request; alloc_ready  out  1  not full.
REQ-009 alloc_pc  in  32, alloc_pred_pc  in  32, alloc_is_br  in  1, alloc_is_store  in  1, alloc_rd  in  5  entry fields.
REQ-010 alloc_id  out  IDX_W  index the next accepted allocation receives (combinational, = tail).
REQ-011 wb_valid  in  NUM_WB; wb_id  in  NUM_WB*IDX_W; wb_value  in  NUM_WB*DATA_W; wb_target  in  NUM_WB*32  resolved next-pc, port k in slice k.
REQ-012 commit_valid  out  1; commit_id  out  IDX_W; commit_rd  out  5; commit_value  out  DATA_W; commit_is_store  out  1.
REQ-013 flush  out  1  one-cycle mispredict pulse; flush_pc  out  32  redirect target.
REQ-014 count  out  IDX_W+1  occupancy; empty  out  1  count==0.

Function
REQ-015 Circular buffer, head (oldest), tail (next free), both wrap DEPTH-1 -> 0.
REQ-016 Allocation accepted on a clock edge with rdy && alloc_valid && alloc_ready && !flush_pending; writes fields, clears entry ready bit, tail+1.
REQ-017 alloc_ready = (count != DEPTH); full exactly when count == DEPTH.
REQ-018 Writeback on port k with wb_valid[k] sets ready, stores value and target into entry wb_id[k]; writeback to an unallocated entry SHALL be ignored.
REQ-019 Two ports hitting same id same cycle: higher port index wins.
REQ-020 Commit: when count>0 and head entry ready, retire head, head+1; at most one per cycle; commit_* registered, valid the following cycle for one cycle.
REQ-021 Retiring branch with target != pred_pc: commit it normally, set flush=1 and flush_pc=target next cycle, and in that same edge clear all ready bits, head=tail=0, count=0.
REQ-022 Allocation presented in the mispredict-detect cycle SHALL be dropped (not counted, alloc_id unchanged on flush cycle to 0).
REQ-023 Simultaneous accepted allocation and commit: count unchanged; full ROB with head committing SHALL NOT accept (alloc_ready uses current count).
REQ-024 rdy low: all registers hold; commit_valid and flush forced 0.
REQ-025 count and empty combinational from registered count.

Reset
REQ-026 rst: head=0, tail=0, count=0, all ready bits 0, commit_valid=0, flush=0, flush_pc=0, commit_id/rd/value/is_store=0; rst dominates rdy.
REQ-027 rst mid-flush or mid-commit: outputs zero the next cycle, no pending retire survives.

Configuration
REQ-028 Macro ROB_WB_BYPASS_EN: defined -> head entry receiving writeback in the current cycle SHALL commit that edge using the writeback value/target (highest-index matching port).
REQ-029 Undefined -> head commits no earlier than the edge after its ready bit is set (one extra cycle latency).

Verification
REQ-030 Reset, then alloc 16 entries DEPTH=16 -> alloc_ready=0 at count=16, 17th request dropped, alloc_id=0 after wrap.
REQ-031 Alloc id0 (rd=5), wb port0 id0 value 0x1234 -> commit_valid one cycle, commit_rd=5, commit_value=0x1234; 1 cycle earlier with ROB_WB_BYPASS_EN than without.
REQ-032 Alloc branch pc=0x100 pred=0x104, plus 3 more; wb target 0x200 -> branch commits, flush=1, flush_pc=0x200, count=0, younger entries never commit.
REQ-033 wb port0 and port1 both id2 values 0xA/0xB same cycle -> commit_value=0xB.
REQ-034 Full ROB, head ready, alloc_valid=1 -> commit occurs, alloc refused, count=15 next cycle.
REQ-035 rdy=0 for 3 cycles with ready head -> no commit_valid, count frozen; commit on first rdy=1 edge.
